// File: rtl/trace_monitor_pkg.sv
// trace_monitor_pkg: shared widths and field types for the trace monitor.
// The full record struct is built in the module since its data field depends on WIDTH.
package trace_monitor_pkg;
  localparam int TS_W = 32;
  localparam int DROP_W = 16;
  localparam int CHAN_IDX_W = 4;
  typedef logic [TS_W-1:0] ts_t;
  typedef logic [CHAN_IDX_W-1:0] chan_t;
endpackage

// File: rtl/trace_monitor_if.sv
// trace_monitor_if: valid/ready record stream from the monitor (master) to its consumer (slave).
interface trace_monitor_if
  import trace_monitor_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  logic out_valid;
  logic out_ready;
  chan_t out_chan;
  logic [WIDTH-1:0] out_data;
  ts_t out_time;
  modport master(output out_valid, out_chan, out_data, out_time, input out_ready);
  modport slave(input out_valid, out_chan, out_data, out_time, output out_ready);
endinterface

// File: rtl/trace_monitor_fifo.sv
// trace_monitor_fifo: DEPTH-entry record queue; accepts a push while full if a pop happens on the same edge.
module trace_monitor_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic wr_en, rd_en;
  // Extra pointer bit tells full from empty when the indices match.
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);
  assign wr_d = wr_q + {{AW{1'b0}}, wr_en};
  assign rd_d = rd_q + {{AW{1'b0}}, rd_en};
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/trace_monitor.sv
// trace_monitor: detects per-channel value changes, timestamps them and queues one record per edge.
// Optional TRACE_MONITOR_DISPLAY_EN prints each popped record in simulation.
module trace_monitor
  import trace_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH = 8,
  parameter int FORMAT_HEX = 0
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic                      en,
  trace_monitor_if.master           out,
  output logic [DROP_W-1:0]         drop_count
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    ts_t ts;
  } hold_t;
  typedef struct packed {
    chan_t chan;
    logic [WIDTH-1:0] data;
    ts_t ts;
  } rec_t;
  ts_t ts_q, ts_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0] drop_sum;
  logic [4:0] ndrop;
  logic [CHANNELS-1:0] pend_w, drop_w;
  hold_t hold_w [CHANNELS];
  hold_t sel_hold;
  chan_t sel;
  logic any_pend, push, pop, full, empty;
  rec_t push_rec, head;
  assign ts_d = ts_q + TS_W'(1);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cur, shadow_q;
    hold_t hold_q;
    logic pend_q, pend_d, chg, clr;
    assign cur = I[c*WIDTH +: WIDTH];
    assign chg = en && (cur != shadow_q);
    assign clr = push && (sel == CHAN_IDX_W'(c));
    // A change landing on the edge that drains this channel re-arms it without counting a drop.
    assign pend_d = chg | (pend_q & ~clr);
    always_ff @(posedge CLK or negedge ASYNCRESETN)
      if (!ASYNCRESETN) begin
        shadow_q <= '0;
        hold_q <= '0;
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_d;
        if (chg) begin
          shadow_q <= cur;
          hold_q <= '{data: cur, ts: ts_d};
        end
      end
    assign pend_w[c] = pend_q;
    assign hold_w[c] = hold_q;
    assign drop_w[c] = chg & pend_q & ~clr;
  end
  always_comb begin
    sel = '0;
    sel_hold = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (pend_w[c]) begin
        sel = CHAN_IDX_W'(c);
        sel_hold = hold_w[c];
      end
  end
  always_comb begin
    ndrop = '0;
    for (int c = 0; c < CHANNELS; c++) ndrop = ndrop + 5'(drop_w[c]);
  end
  assign drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(ndrop);
  assign drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  assign any_pend = |pend_w;
  assign pop = !empty && out.out_ready;
  assign push = any_pend && (!full || pop);
  assign push_rec = '{chan: sel, data: sel_hold.data, ts: sel_hold.ts};
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) begin
      ts_q <= '0;
      drop_q <= '0;
    end else begin
      ts_q <= ts_d;
      drop_q <= drop_d;
    end
  trace_monitor_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
    .clk    (CLK),
    .rst_n  (ASYNCRESETN),
    .push_i (push),
    .data_i (push_rec),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .data_o (head)
  );
  assign out.out_valid = !empty;
  assign out.out_chan = head.chan;
  assign out.out_data = head.data;
  assign out.out_time = head.ts;
  assign drop_count = drop_q;
`ifdef TRACE_MONITOR_DISPLAY_EN
  always @(posedge CLK)
    if (ASYNCRESETN && pop) begin
      if (FORMAT_HEX != 0) $display("%0t ch%0d %0h", $time, head.chan, head.data);
      else $display("%0t ch%0d %0d", $time, head.chan, head.data);
    end
`else
  logic unused_fmt;
  assign unused_fmt = FORMAT_HEX != 0;
`endif
endmodule

// File: tb/tb_trace_monitor.sv
// tb_trace_monitor: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_trace_monitor;
  localparam int W = 8;
  localparam int CH = 4;
  localparam int D = 8;
  typedef struct {
    int chan;
    int data;
    logic [31:0] ts;
  } mrec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [CH*W-1:0] din = '0;
  logic [15:0] drop;
  int n_chk = 0;
  int n_pass = 0;
  mrec_t q[$];
  int m_shadow[CH];
  int m_pval[CH];
  logic [31:0] m_pts[CH];
  bit m_pend[CH];
  int m_drop;
  logic [31:0] m_ts;

  trace_monitor_if #(.WIDTH(W)) tif ();
  trace_monitor #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
    .CLK        (clk),
    .ASYNCRESETN(rst_n),
    .I          (din),
    .en         (en),
    .out        (tif),
    .drop_count (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ts = '0;
    for (int c = 0; c < CH; c++) begin
      m_shadow[c] = 0;
      m_pval[c] = 0;
      m_pts[c] = '0;
      m_pend[c] = 0;
    end
  endtask

  // One clock edge of the specified behaviour: pop, drain lowest pending, then sample changes.
  task automatic model_edge();
    int v;
    bit popped;
    popped = q.size() > 0 && tif.out_ready;
    m_ts = m_ts + 32'd1;
    if (popped) void'(q.pop_front());
    for (int c = 0; c < CH; c++)
      if (m_pend[c]) begin
        if (q.size() < D) begin
          q.push_back('{chan: c, data: m_pval[c], ts: m_pts[c]});
          m_pend[c] = 0;
        end
        break;
      end
    for (int c = 0; c < CH; c++) begin
      v = int'(din[c*W +: W]);
      if (en && v != m_shadow[c]) begin
        m_shadow[c] = v;
        if (m_pend[c] && m_drop < 65535) m_drop++;
        m_pend[c] = 1;
        m_pval[c] = v;
        m_pts[c] = m_ts;
      end
    end
  endtask

  task automatic check_out();
    check("valid", tif.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("chan", tif.out_chan, q[0].chan);
      check("data", tif.out_data, q[0].data);
      check("time", tif.out_time, q[0].ts);
    end
    check("drop", drop, m_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_out();
  endtask

  task automatic set_ch(input int c, input int v);
    din[c*W +: W] = v[W-1:0];
  endtask

  initial begin
    tif.out_ready = 1'b0;
    en = 1'b1;
    model_reset();
    #1;
    check("rst_valid", tif.out_valid, 0);
    check("rst_chan", tif.out_chan, 0);
    check("rst_data", tif.out_data, 0);
    check("rst_time", tif.out_time, 0);
    check("rst_drop", drop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single change sampled at edge 3
    tick();
    tick();
    set_ch(1, 5);
    tick();
    check("r33_nobypass", tif.out_valid, 0);
    tick();
    check("r33_valid", tif.out_valid, 1);
    check("r33_chan", tif.out_chan, 1);
    check("r33_data", tif.out_data, 5);
    check("r33_time", tif.out_time, 3);
    tif.out_ready = 1'b1;
    tick();
    tif.out_ready = 1'b0;
    // simultaneous changes: lower channel first, same timestamp
    set_ch(0, 8'h3c);
    set_ch(2, 8'h81);
    tick();
    tick();
    check("r34_first", tif.out_chan, 0);
    tick();
    tif.out_ready = 1'b1;
    tick();
    check("r34_second", tif.out_chan, 2);
    check("r34_drop", drop, 0);
    tick();
    // stall with a toggling channel: queue fills, later changes coalesce
    tif.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din[W-1:0] = ~din[W-1:0];
      tick();
    end
    check("r35_full_valid", tif.out_valid, 1);
    check("r35_dropnz", drop != 0, 1);
    tif.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    // disabled sampling
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = {$urandom(), $urandom()};
      tick();
    end
    check("r36_idle", tif.out_valid, 0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 3) == 0) set_ch(c, $urandom_range(0, 255));
      en = $urandom_range(0, 9) != 0;
      tif.out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    // reset with records queued
    en = 1'b1;
    tif.out_ready = 1'b0;
    din = '0;
    tick();
    set_ch(0, 8'h11);
    set_ch(1, 8'h22);
    set_ch(2, 8'h33);
    tick();
    din = '0;
    for (int i = 0; i < 5; i++) tick();
    check("r37_queued", q.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    check("r37_drop_valid", tif.out_valid, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("r37_empty", tif.out_valid, 0);
    // timestamp wrap
    force dut.ts_q = 32'hffff_fffe;
    #1;
    release dut.ts_q;
    m_ts = 32'hffff_fffe;
    set_ch(0, 8'h11);
    tick();
    set_ch(1, 8'h22);
    tick();
    check("r38_pre", tif.out_time, 32'hffff_ffff);
    tick();
    check("r38_post", tif.out_time, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
